// File: rtl/adc_acq_sequencer.sv
// rtl/adc_acq_sequencer.sv - acquisition sequencer: pre-fill, armed, post capture, holdoff, done.
// Drives the trigger block enable/reset and the capture ring write address.
module adc_acq_sequencer #(
  parameter int CNT_W   = 24,
  parameter int WADDR_W = 14
) (
  input  logic               adc_data_clk,
  input  logic               adc_data_rst_n,
  input  logic               acq_run,
  input  logic               acq_abort,
  input  logic               acq_single,
  input  logic               auto_trig_en,
  input  logic [CNT_W-1:0]   pre_len,
  input  logic [CNT_W-1:0]   post_len,
  input  logic [CNT_W-1:0]   holdoff_len,
  input  logic [CNT_W-1:0]   auto_timeout,
  input  logic               trig_in,
  input  logic [2:0]         trig_sub_in,
  output logic               trig_enable,
  output logic               trig_core_rst,
  output logic               wr_en,
  output logic [WADDR_W-1:0] wr_addr,
  output logic [WADDR_W-1:0] trig_addr,
  output logic [2:0]         trig_sub,
  output logic               trig_auto,
  output logic               acq_done,
  output logic               acq_busy,
  output logic [2:0]         acq_state,
  output logic [15:0]        acq_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
  localparam logic [WADDR_W-1:0] ADDR_ONE = 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               run_q;
  logic               core_rst_q, core_rst_d;
  logic [WADDR_W-1:0] wr_addr_q;
  logic [WADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [2:0]         trig_sub_q, trig_sub_d;
  logic               trig_auto_q, trig_auto_d;
  logic [15:0]        count_q;

  logic run_rise, cnt_last, auto_hit;

  assign run_rise = acq_run & ~run_q;
  assign cnt_last = (cnt_q == len_q - CNT_ONE);
  // len_q holds auto_timeout while ARMED; a zero timeout never fires.
  assign auto_hit = auto_trig_en && (len_q != '0) && cnt_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    len_d       = len_q;
    core_rst_d  = 1'b0;
    trig_addr_d = trig_addr_q;
    trig_sub_d  = trig_sub_q;
    trig_auto_d = trig_auto_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run_rise) begin
          state_d    = (pre_len != '0) ? S_PRE : S_ARMED;
          core_rst_d = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_last) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig_in || auto_hit) begin
          trig_addr_d = wr_addr_q;
          trig_sub_d  = trig_in ? trig_sub_in : 3'd0;
          trig_auto_d = ~trig_in;
          if (post_len != '0)         state_d = S_POST;
          else if (holdoff_len != '0) state_d = S_HOLD;
          else                        state_d = S_DONE;
        end
      end
      S_POST: begin
        if (cnt_last) state_d = (holdoff_len != '0) ? S_HOLD : S_DONE;
      end
      S_HOLD: begin
        if (cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (acq_single || !acq_run) begin
          state_d = S_IDLE;
        end else begin
          state_d    = (pre_len != '0) ? S_PRE : S_ARMED;
          core_rst_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (acq_abort) begin
      state_d     = S_IDLE;
      core_rst_d  = 1'b0;
      trig_addr_d = trig_addr_q;
      trig_sub_d  = trig_sub_q;
      trig_auto_d = trig_auto_q;
    end

    // Every state entry restarts the counter and latches that state's length.
    if (state_d != state_q) begin
      cnt_d = '0;
      case (state_d)
        S_PRE:   len_d = pre_len;
        S_ARMED: len_d = auto_timeout;
        S_POST:  len_d = post_len;
        S_HOLD:  len_d = holdoff_len;
        default: len_d = '0;
      endcase
    end
  end

  always_ff @(posedge adc_data_clk or negedge adc_data_rst_n) begin
    if (!adc_data_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      run_q       <= 1'b0;
      core_rst_q  <= 1'b0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      trig_sub_q  <= 3'd0;
      trig_auto_q <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      run_q       <= acq_run;
      core_rst_q  <= core_rst_d;
      trig_addr_q <= trig_addr_d;
      trig_sub_q  <= trig_sub_d;
      trig_auto_q <= trig_auto_d;
      if (wr_en)    wr_addr_q <= wr_addr_q + ADDR_ONE;
      if (acq_done) count_q   <= count_q + 16'd1;
    end
  end

  // Abort suppresses the strobes in the cycle it is asserted.
  assign wr_en         = ((state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST)) && !acq_abort;
  assign trig_enable   = ((state_q == S_PRE) || (state_q == S_ARMED)) && !acq_abort;
  assign acq_done      = (state_q == S_DONE) && !acq_abort;
  assign acq_busy      = (state_q != S_IDLE);
  assign acq_state     = state_q;
  assign trig_core_rst = core_rst_q;
  assign wr_addr       = wr_addr_q;
  assign trig_addr     = trig_addr_q;
  assign trig_sub      = trig_sub_q;
  assign trig_auto     = trig_auto_q;
  assign acq_count     = count_q;

endmodule
